// File: rtl/id_stage.sv
// id_stage: RV32I decode stage (LUI, AUIPC, ADDI, ADD, SUB) feeding the EX ALU.
//
// Decodes one instruction per cycle into a 5-bit ALUOp and operands A/B,
// reads the register file combinationally, and holds the result in one
// pipeline register toward EX. Illegal encodings become NOPs and are counted
// in a saturating counter.
//
// Optional feature macro: ID_BYPASS_EN
//   defined   -> writeback data is forwarded onto matching source operands.
//   undefined -> wb_* inputs are ignored and operands come only from rf_rdata
//                (the regfile must then be write-first).
//
// Handshake: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. in_valid/out_valid never depend on the matching
// ready. in_ready is combinational from out_ready (the register is free when
// empty or being drained this cycle). While out_valid=1 and out_ready=0 the
// registered payload is held unchanged.
module id_stage #(
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic                 wb_we,
  input  logic [4:0]           wb_waddr,
  input  logic [31:0]          wb_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_alu_op,
  output logic [31:0]          out_a,
  output logic [31:0]          out_b,
  output logic [4:0]           out_rd,
  output logic                 out_reg_we,
  output logic [31:0]          out_pc,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  // Major opcodes of the supported subset
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  // ALUOp encodings understood by EX
  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_u;
  logic [31:0] imm_i;

  // Resolved source operands
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  // Decode results
  logic        dec_legal;
  logic [4:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_reg_we;

  // Handshake
  logic        accept;

  // Pipeline register state
  logic                 out_valid_q,  out_valid_d;
  logic [4:0]           alu_op_q,     alu_op_d;
  logic [31:0]          a_q,          a_d;
  logic [31:0]          b_q,          b_d;
  logic [4:0]           rd_q,         rd_d;
  logic                 reg_we_q,     reg_we_d;
  logic [31:0]          pc_q,         pc_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q,    ill_cnt_d;

  // Field extraction; register-file addresses come straight from the word
  always_comb begin
    opcode  = in_instr[6:0];
    rd_idx  = in_instr[11:7];
    funct3  = in_instr[14:12];
    rs1_idx = in_instr[19:15];
    rs2_idx = in_instr[24:20];
    funct7  = in_instr[31:25];
    imm_u   = {in_instr[31:12], 12'b0};
    imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  end

  assign rf_raddr1 = rs1_idx;
  assign rf_raddr2 = rs2_idx;

`ifdef ID_BYPASS_EN
  // Source operand select: x0 forces zero, otherwise forward a matching writeback
  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (wb_we && (wb_waddr != 5'd0) && (wb_waddr == rs1_idx)) begin
      rs1_val = wb_wdata;
    end
    if (wb_we && (wb_waddr != 5'd0) && (wb_waddr == rs2_idx)) begin
      rs2_val = wb_wdata;
    end
    if (rs1_idx == 5'd0) begin
      rs1_val = 32'd0;
    end
    if (rs2_idx == 5'd0) begin
      rs2_val = 32'd0;
    end
  end
`else
  // Writeback ports are present but intentionally ignored in this build
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};

  // Source operand select: x0 forces zero, otherwise use regfile data as-is
  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (rs1_idx == 5'd0) begin
      rs1_val = 32'd0;
    end
    if (rs2_idx == 5'd0) begin
      rs2_val = 32'd0;
    end
  end
`endif

  // Decode the supported subset; anything else becomes a NOP with zero operands
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_NOP;
    dec_a     = 32'd0;
    dec_b     = 32'd0;
    unique case (opcode)
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op    = ALU_LUI;
        dec_a     = 32'd0;
        dec_b     = imm_u;
      end
      OPC_AUIPC: begin
        // EX passes B through for auipc, so B carries the finished sum
        dec_legal = 1'b1;
        dec_op    = ALU_AUIPC;
        dec_a     = in_pc;
        dec_b     = in_pc + imm_u;
      end
      OPC_OPIMM: begin
        if (funct3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_ADD;
          dec_a     = rs1_val;
          dec_b     = imm_i;
        end
      end
      OPC_OP: begin
        if ((funct3 == F3_ADD) && (funct7 == F7_ADD)) begin
          dec_legal = 1'b1;
          dec_op    = ALU_ADD;
          dec_a     = rs1_val;
          dec_b     = rs2_val;
        end else if ((funct3 == F3_ADD) && (funct7 == F7_SUB)) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
          dec_a     = rs1_val;
          dec_b     = rs2_val;
        end
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    // Writes to x0 are suppressed here so EX/WB need not check rd
    dec_reg_we = dec_legal && (rd_idx != 5'd0);
  end

  // Ready when the register is empty or its entry retires this cycle
  always_comb begin
    in_ready = ~rst & (~out_valid_q | out_ready);
    accept   = in_valid & in_ready & ~flush;
  end

  // Next-state for the pipeline register and the illegal counter
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    pc_d        = pc_q;
    ill_cnt_d   = ill_cnt_q;
    if (flush) begin
      // Kill the held entry; payload is left as-is since valid gates it
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_op;
      a_d         = dec_a;
      b_d         = dec_b;
      rd_d        = rd_idx;
      reg_we_d    = dec_reg_we;
      pc_d        = in_pc;
      if (!dec_legal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
        ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
      end
    end else if (out_ready) begin
      // Entry retired and nothing replaced it
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= ALU_NOP;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rd_q        <= 5'd0;
      reg_we_q    <= 1'b0;
      pc_q        <= 32'd0;
      ill_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      pc_q        <= pc_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_alu_op  = alu_op_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_rd      = rd_q;
  assign out_reg_we  = reg_we_q;
  assign out_pc      = pc_q;
  assign illegal_cnt = ill_cnt_q;

endmodule
